// File: rtl/rack_spike_tx.sv
// Rack spike link transmitter: queues raw spike strobes and emits fixed-width
// pulses with a guaranteed low gap. Optional counters under SPIKE_TX_STATS_EN.
module rack_spike_tx #(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_in,
  output logic             spikeout,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic [31:0]      sent_cnt,
  output logic [15:0]      dropped_cnt
);

  localparam int unsigned TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]    PULSE_LD = TW'(PULSE_W - 1);
  localparam logic [TW-1:0]    GAP_LD   = TW'(GAP_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             spikeout_q, spikeout_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             start_c;
  logic             inc_c;
  logic             sat_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      spikeout_q <= 1'b0;
      busy_q     <= 1'b0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      spikeout_q <= spikeout_d;
      busy_q     <= busy_d;
      pend_q     <= pend_d;
    end
  end

  // Pulse sequencer; a pulse start can come from IDLE or straight out of an expiring GAP.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    spikeout_d = spikeout_q;
    start_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (pend_q != '0)) start_c = 1'b1;
      end
      HIGH: begin
        if (timer_q == '0) begin
          state_d    = GAP;
          spikeout_d = 1'b0;
          timer_d    = GAP_LD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          if (enable && (pend_q != '0)) start_c = 1'b1;
          else                          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        spikeout_d = 1'b0;
      end
    endcase
    if (start_c) begin
      state_d    = HIGH;
      spikeout_d = 1'b1;
      timer_d    = PULSE_LD;
    end
    busy_d = (state_d != IDLE);
  end

  // Saturating queue of spikes not yet started; flushed while disabled.
  always_comb begin
    inc_c  = enable & spike_in;
    sat_c  = (pend_q == CNT_MAX);
    pend_d = pend_q;
    if (!enable) begin
      pend_d = '0;
    end else if (inc_c && !start_c) begin
      if (!sat_c) pend_d = pend_q + CNT_W'(1);
    end else if (!inc_c && start_c) begin
      pend_d = pend_q - CNT_W'(1);
    end
  end

  assign spikeout = spikeout_q;
  assign busy     = busy_q;
  assign pending  = pend_q;

`ifdef SPIKE_TX_STATS_EN
  logic [31:0] sent_q;
  logic [15:0] dropped_q;
  logic        drop_c;

  assign drop_c = inc_c & sat_c & ~start_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sent_q    <= '0;
      dropped_q <= '0;
    end else begin
      if (start_c) sent_q <= sent_q + 32'd1;
      if (drop_c && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 16'd1;
    end
  end

  assign sent_cnt    = sent_q;
  assign dropped_cnt = dropped_q;
`else
  assign sent_cnt    = 32'd0;
  assign dropped_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rack_spike_tx.sv
// Directed bench for rack_spike_tx: pulse-width/gap scoreboard plus cycle checks
// of pending, busy and (when SPIKE_TX_STATS_EN is defined) the counters.
module tb_rack_spike_tx;

  localparam int unsigned PW = 4;
  localparam int unsigned GW = 4;
`ifdef SPIKE_TX_STATS_EN
  localparam int unsigned STATS = 1;
`else
  localparam int unsigned STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, spike_in;
  logic        spikeout, busy;
  logic [7:0]  pending;
  logic [31:0] sent_cnt;
  logic [15:0] dropped_cnt;

  logic        sat_en, sat_spk;
  logic        sat_out, sat_busy;
  logic [1:0]  sat_pend;
  logic [31:0] sat_sent;
  logic [15:0] sat_drop;

  int n_vec = 0;
  int n_err = 0;

  int exp_w[$];
  int obs_w[$];
  int gap_q[$];
  int sat_pulses = 0;

  always #5 clk = ~clk;

  rack_spike_tx #(.PULSE_W(PW), .GAP_W(GW), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
    .spikeout(spikeout), .busy(busy), .pending(pending),
    .sent_cnt(sent_cnt), .dropped_cnt(dropped_cnt)
  );

  rack_spike_tx #(.PULSE_W(PW), .GAP_W(GW), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .enable(sat_en), .spike_in(sat_spk),
    .spikeout(sat_out), .busy(sat_busy), .pending(sat_pend),
    .sent_cnt(sat_sent), .dropped_cnt(sat_drop)
  );

  // Measures high widths and low gaps of the main line between clock edges.
  int  hi_run = 0, lo_run = 0;
  bit  prev = 1'b0, seen = 1'b0, sat_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      hi_run = 0; lo_run = 0; prev = 1'b0; seen = 1'b0; sat_prev = 1'b0;
    end else begin
      if (spikeout) begin
        if (!prev && seen) gap_q.push_back(lo_run);
        hi_run = hi_run + 1;
      end else if (prev) begin
        obs_w.push_back(hi_run);
        hi_run = 0; lo_run = 1; seen = 1'b1;
      end else begin
        lo_run = lo_run + 1;
      end
      prev = spikeout;
      if (sat_out && !sat_prev) sat_pulses = sat_pulses + 1;
      sat_prev = sat_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || pending != 8'd0) && n < 200) begin
      step();
      n = n + 1;
    end
    check(tag, 32'(busy), 32'd0);
    repeat (2) step();
  endtask

  task automatic drain_pulses(input string tag);
    while (exp_w.size() > 0) begin
      int e = exp_w.pop_front();
      if (obs_w.size() == 0) check(tag, 32'd0, 32'(e));
      else                   check(tag, 32'(obs_w.pop_front()), 32'(e));
    end
    check({tag, "_extra"}, 32'(obs_w.size()), 32'd0);
  endtask

  task automatic check_gaps(input string tag, input int n_exp);
    check({tag, "_n"}, 32'(gap_q.size()), 32'(n_exp));
    if (gap_q.size() > 0) void'(gap_q.pop_front());
    while (gap_q.size() > 0) check(tag, 32'(gap_q.pop_front()), 32'(GW));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; spike_in = 1'b0; sat_en = 1'b0; sat_spk = 1'b0;
    repeat (3) step();
    check("rst_spikeout", 32'(spikeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_sent", sent_cnt, 32'd0);
    check("rst_dropped", 32'(dropped_cnt), 32'd0);
    reset = 1'b1; enable = 1'b1; sat_en = 1'b1;
    repeat (2) step();

    // Single spike: 2-cycle latency, 4 high, 4 low, then IDLE.
    exp_w.push_back(PW);
    spike_in = 1'b1; step();
    check("single_pend_q", 32'(pending), 32'd1);
    check("single_no_comb", 32'(spikeout), 32'd0);
    spike_in = 1'b0; step();
    check("single_high", 32'(spikeout), 32'd1);
    check("single_pend_dec", 32'(pending), 32'd0);
    check("single_sent", sent_cnt, 32'(1 * STATS));
    repeat (3) step();
    check("single_high_last", 32'(spikeout), 32'd1);
    step();
    check("single_low", 32'(spikeout), 32'd0);
    check("single_gap_busy", 32'(busy), 32'd1);
    repeat (3) step();
    check("single_gap_end_busy", 32'(busy), 32'd1);
    step();
    check("single_idle", 32'(busy), 32'd0);
    repeat (2) step();
    drain_pulses("single_width");

    // Burst of 5: pending peaks at 4, pulses back-to-back.
    gap_q.delete();
    repeat (5) exp_w.push_back(PW);
    spike_in = 1'b1;
    repeat (5) step();
    check("burst_peak", 32'(pending), 32'd4);
    spike_in = 1'b0;
    wait_idle("burst_idle");
    drain_pulses("burst_width");
    check_gaps("burst_gap", 5);
    check("burst_sent", sent_cnt, 32'(6 * STATS));

    // Spike coinciding with GAP expiry while pending=1.
    gap_q.delete();
    repeat (3) exp_w.push_back(PW);
    spike_in = 1'b1; step(); step();
    spike_in = 1'b0;
    repeat (7) step();
    check("simul_pre_pend", 32'(pending), 32'd1);
    check("simul_pre_low", 32'(spikeout), 32'd0);
    spike_in = 1'b1; step();
    check("simul_pend_hold", 32'(pending), 32'd1);
    check("simul_restart", 32'(spikeout), 32'd1);
    check("simul_sent", sent_cnt, 32'(8 * STATS));
    spike_in = 1'b0;
    wait_idle("simul_idle");
    drain_pulses("simul_width");
    check_gaps("simul_gap", 3);

    // Disable mid-pulse with pending=3: pulse completes, queue flushed.
    exp_w.push_back(PW);
    spike_in = 1'b1;
    repeat (4) step();
    check("dis_pend3", 32'(pending), 32'd3);
    enable = 1'b0; step();
    check("dis_flush", 32'(pending), 32'd0);
    check("dis_still_high", 32'(spikeout), 32'd1);
    step();
    check("dis_low", 32'(spikeout), 32'd0);
    repeat (3) step();
    check("dis_gap_busy", 32'(busy), 32'd1);
    step();
    check("dis_idle", 32'(busy), 32'd0);
    repeat (5) step();
    check("dis_no_pulse", 32'(spikeout), 32'd0);
    check("dis_pend_zero", 32'(pending), 32'd0);
    check("dis_dropped", 32'(dropped_cnt), 32'd0);
    drain_pulses("dis_width");
    spike_in = 1'b0; enable = 1'b1; step();
    exp_w.push_back(PW);
    spike_in = 1'b1; step();
    check("reen_queued", 32'(pending), 32'd1);
    spike_in = 1'b0;
    wait_idle("reen_idle");
    drain_pulses("reen_width");
    check("reen_sent", sent_cnt, 32'(11 * STATS));

    // Saturation, CNT_W=2: the 10th spike lands on the second pulse start, so
    // drops occur only on the 5 edges where the counter sits at 3 without a start.
    sat_spk = 1'b1;
    repeat (5) step();
    check("sat_cap_early", 32'(sat_pend), 32'd3);
    repeat (5) step();
    check("sat_cap", 32'(sat_pend), 32'd3);
    check("sat_dropped", 32'(sat_drop), 32'(5 * STATS));
    sat_spk = 1'b0;
    for (int i = 0; i < 200 && (sat_busy || sat_pend != 2'd0); i++) step();
    repeat (2) step();
    check("sat_idle", 32'(sat_busy), 32'd0);
    check("sat_pulses", 32'(sat_pulses), 32'd5);
    check("sat_sent", sat_sent, 32'(5 * STATS));

    // Asynchronous reset during HIGH clears everything before the next edge.
    spike_in = 1'b1; step();
    spike_in = 1'b0; step(); step();
    check("rstm_high", 32'(spikeout), 32'd1);
    check("rstm_sent_pre", sent_cnt, 32'(12 * STATS));
    #2 reset = 1'b0;
    #1;
    check("rstm_spikeout", 32'(spikeout), 32'd0);
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_pending", 32'(pending), 32'd0);
    check("rstm_sent", sent_cnt, 32'd0);
    check("rstm_dropped", 32'(sat_drop), 32'd0);
    #3 reset = 1'b1;
    repeat (2) step();
    check("rstm_after", 32'(spikeout), 32'd0);
    check("rstm_no_stray", 32'(obs_w.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
